// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer: walks an output feature map in (ox, oy, of) tiles,
// innermost ox, then oy, then of. For each tile it publishes the 1-based tile
// origin and the edge-clipped extents, then runs one compute handshake and one
// store handshake before moving on to the next tile.
module conv_tile_sequencer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          layer_start,
  input  logic [DW-1:0] out_x,
  input  logic [DW-1:0] out_y,
  input  logic [DW-1:0] out_f,
  input  logic [DW-1:0] tile_x,
  input  logic [DW-1:0] tile_y,
  input  logic [DW-1:0] tile_f,
  input  logic          compute_done,
  input  logic          store_done,
  output logic [DW-1:0] cur_ox_start,
  output logic [DW-1:0] cur_oy_start,
  output logic [DW-1:0] cur_of_start,
  output logic [DW-1:0] cur_pox,
  output logic [DW-1:0] cur_poy,
  output logic [DW-1:0] cur_pof,
  output logic          compute_start,
  output logic          conv_store_start,
  output logic          busy,
  output logic          layer_done,
  output logic [DW-1:0] tile_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SIZE    = 3'd1;
  localparam logic [2:0] S_CISSUE  = 3'd2;
  localparam logic [2:0] S_CWAIT   = 3'd3;
  localparam logic [2:0] S_SISSUE  = 3'd4;
  localparam logic [2:0] S_SWAIT   = 3'd5;
  localparam logic [2:0] S_ADVANCE = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [DW:0]   ONE_W = (DW+1)'(1);
  localparam logic [DW-1:0] ONE   = DW'(1);

  logic [2:0]    state;
  logic [DW-1:0] out_x_q, out_y_q, out_f_q;
  logic [DW-1:0] tile_x_q, tile_y_q, tile_f_q;

  // One-past-the-end coordinate of the current tile along each axis,
  // kept at DW+1 bits so a tile ending exactly at 2^DW-1 does not wrap.
  logic [DW:0] end_x, end_y, end_f;
  logic        past_x, past_y, past_f;
  logic        last_tile;
  logic        any_zero;

  // Clipped extent: min(tile, total - start + 1); start never exceeds total.
  function automatic logic [DW-1:0] clip(input logic [DW-1:0] tile,
                                         input logic [DW-1:0] total,
                                         input logic [DW-1:0] start);
    logic [DW:0] rem;
    rem = {1'b0, total} - {1'b0, start} + ONE_W;
    return ({1'b0, tile} < rem) ? tile : rem[DW-1:0];
  endfunction

  // Tile-end arithmetic shared by the last-tile test and the ADVANCE step.
  always_comb begin
    end_x     = {1'b0, cur_ox_start} + {1'b0, cur_pox};
    end_y     = {1'b0, cur_oy_start} + {1'b0, cur_poy};
    end_f     = {1'b0, cur_of_start} + {1'b0, cur_pof};
    past_x    = end_x > {1'b0, out_x_q};
    past_y    = end_y > {1'b0, out_y_q};
    past_f    = end_f > {1'b0, out_f_q};
    last_tile = past_x && past_y && past_f;
    any_zero  = (out_x == '0) || (out_y == '0) || (out_f == '0) ||
                (tile_x == '0) || (tile_y == '0) || (tile_f == '0);
  end

  // Pulses and busy decode straight from the state register, so they are
  // glitch-free and need no extra clear logic on reset.
  assign compute_start    = (state == S_CISSUE);
  assign conv_store_start = (state == S_SISSUE);
  assign layer_done       = (state == S_DONE);
  assign busy             = (state != S_IDLE);

  // Sequencer state, latched layer config, tile cursor and tile counter.
  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so all assignments are
    // non-blocking; blocking ones would let later lines see new values.
    if (reset) begin
      state        <= S_IDLE;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_f_q      <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      tile_f_q     <= '0;
      cur_ox_start <= '0;
      cur_oy_start <= '0;
      cur_of_start <= '0;
      cur_pox      <= '0;
      cur_poy      <= '0;
      cur_pof      <= '0;
      tile_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (layer_start) begin
            out_x_q      <= out_x;
            out_y_q      <= out_y;
            out_f_q      <= out_f;
            tile_x_q     <= tile_x;
            tile_y_q     <= tile_y;
            tile_f_q     <= tile_f;
            cur_ox_start <= ONE;
            cur_oy_start <= ONE;
            cur_of_start <= ONE;
            tile_count   <= '0;
            state        <= any_zero ? S_DONE : S_SIZE;
          end
        end
        S_SIZE: begin
          cur_pox <= clip(tile_x_q, out_x_q, cur_ox_start);
          cur_poy <= clip(tile_y_q, out_y_q, cur_oy_start);
          cur_pof <= clip(tile_f_q, out_f_q, cur_of_start);
          state   <= S_CISSUE;
        end
        S_CISSUE: state <= S_CWAIT;
        S_CWAIT: begin
          if (compute_done) state <= S_SISSUE;
        end
        S_SISSUE: state <= S_SWAIT;
        S_SWAIT: begin
          if (store_done) begin
            tile_count <= tile_count + ONE;
            state      <= last_tile ? S_DONE : S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (!past_x) begin
            cur_ox_start <= end_x[DW-1:0];
          end else begin
            cur_ox_start <= ONE;
            if (!past_y) begin
              cur_oy_start <= end_y[DW-1:0];
            end else begin
              cur_oy_start <= ONE;
              cur_of_start <= end_f[DW-1:0];
            end
          end
          state <= S_SIZE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Self-checking bench for conv_tile_sequencer: directed layers from the test
// plan plus randomized layers, checked against a nested-loop tiling model.
module tb_conv_tile_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          layer_start;
  logic [DW-1:0] out_x, out_y, out_f, tile_x, tile_y, tile_f;
  logic          compute_done, store_done;
  logic [DW-1:0] cur_ox_start, cur_oy_start, cur_of_start;
  logic [DW-1:0] cur_pox, cur_poy, cur_pof;
  logic          compute_start, conv_store_start, busy, layer_done;
  logic [DW-1:0] tile_count;

  conv_tile_sequencer #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .layer_start(layer_start),
    .out_x(out_x), .out_y(out_y), .out_f(out_f),
    .tile_x(tile_x), .tile_y(tile_y), .tile_f(tile_f),
    .compute_done(compute_done), .store_done(store_done),
    .cur_ox_start(cur_ox_start), .cur_oy_start(cur_oy_start),
    .cur_of_start(cur_of_start),
    .cur_pox(cur_pox), .cur_poy(cur_poy), .cur_pof(cur_pof),
    .compute_start(compute_start), .conv_store_start(conv_store_start),
    .busy(busy), .layer_done(layer_done), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ox, oy, of, pox, poy, pof;
  } tile_t;

  tile_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are then read 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference tiling: plain nested loops, f outermost, x innermost.
  task automatic build_model(input int ox, input int oy, input int of,
                             input int tx, input int ty, input int tf);
    exp_q.delete();
    if (ox == 0 || oy == 0 || of == 0 || tx == 0 || ty == 0 || tf == 0) return;
    for (int f = 1; f <= of; f += imin(tf, of - f + 1))
      for (int y = 1; y <= oy; y += imin(ty, oy - y + 1))
        for (int x = 1; x <= ox; x += imin(tx, ox - x + 1)) begin
          tile_t t;
          t.ox = x; t.oy = y; t.of = f;
          t.pox = imin(tx, ox - x + 1);
          t.poy = imin(ty, oy - y + 1);
          t.pof = imin(tf, of - f + 1);
          exp_q.push_back(t);
        end
  endtask

  task automatic scramble_config;
    out_x  = DW'($urandom); out_y  = DW'($urandom); out_f  = DW'($urandom);
    tile_x = DW'($urandom); tile_y = DW'($urandom); tile_f = DW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cs"}, compute_start, 0);
    check({tag, "_ss"}, conv_store_start, 0);
    check({tag, "_ld"}, layer_done, 0);
    check({tag, "_tcnt"}, tile_count, 0);
    check({tag, "_starts"}, {cur_ox_start, cur_oy_start, cur_of_start}, 0);
    check({tag, "_extents"}, {cur_pox, cur_poy, cur_pof}, 0);
  endtask

  // Run one layer. cd/sd: cycles spent in CWAIT/SWAIT before the done pulse
  // (negative = random 0..3). spur: inject ignored handshakes. abort_at:
  // tile index whose SWAIT gets a reset instead of store_done (-1 = none).
  task automatic do_layer(input int ox, input int oy, input int of,
                          input int tx, input int ty, input int tf,
                          input int cd, input int sd, input bit spur,
                          input int abort_at);
    int m, d, w;
    build_model(ox, oy, of, tx, ty, tf);
    out_x = DW'(ox); out_y = DW'(oy); out_f = DW'(of);
    tile_x = DW'(tx); tile_y = DW'(ty); tile_f = DW'(tf);
    layer_start = 1'b1;
    cyc = 0;
    tick;
    layer_start = 1'b0;
    scramble_config;
    check("busy_c1", busy, 1);
    check("tcnt_c1", tile_count, 0);
    if (exp_q.size() == 0) begin
      check("zero_done", layer_done, 1);
      check("zero_pulses", {compute_start, conv_store_start}, 0);
      tick;
      check("zero_idle", busy, 0);
      check("zero_pulses2", {compute_start, conv_store_start, layer_done}, 0);
      return;
    end
    m = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tile_t t;
      t = exp_q[i];
      w = 0;
      while (!compute_start && w < 20) begin
        tick;
        w++;
      end
      if (!compute_start) begin
        check("cs_timeout", 0, 1);
        reset = 1'b1; tick; reset = 1'b0;
        return;
      end
      check("cs_cycle", cyc, (i == 0) ? 2 : m + 3);
      check("ox_start", cur_ox_start, t.ox);
      check("oy_start", cur_oy_start, t.oy);
      check("of_start", cur_of_start, t.of);
      check("pox", cur_pox, t.pox);
      check("poy", cur_poy, t.poy);
      check("pof", cur_pof, t.pof);
      tick;
      check("cs_pulse", compute_start, 0);
      d = (cd < 0) ? int'($urandom_range(0, 3)) : cd;
      repeat (d) begin
        if (spur) begin
          store_done  = 1'b1;
          layer_start = 1'b1;
        end
        tick;
        store_done  = 1'b0;
        layer_start = 1'b0;
        check("cwait_hold", {conv_store_start, busy}, 2'b01);
      end
      compute_done = 1'b1;
      tick;
      compute_done = 1'b0;
      check("ss_pulse", conv_store_start, 1);
      tick;
      check("ss_low", conv_store_start, 0);
      d = (sd < 0) ? int'($urandom_range(0, 3)) : sd;
      repeat (d) begin
        if (spur) compute_done = 1'b1;
        tick;
        compute_done = 1'b0;
        check("swait_hold", {compute_start, tile_count}, i);
      end
      if (abort_at == i) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_all_zero("rst");
        repeat (3) begin
          tick;
          check("rst_quiet", {compute_start, conv_store_start, layer_done, busy}, 0);
        end
        return;
      end
      store_done = 1'b1;
      if (spur) compute_done = 1'b1;
      m = cyc;
      tick;
      store_done   = 1'b0;
      compute_done = 1'b0;
      check("tcnt", tile_count, i + 1);
      if (i == exp_q.size() - 1) begin
        check("ldone", layer_done, 1);
        tick;
        check("ldone_end", {layer_done, busy}, 0);
      end else begin
        check("mid_layer", {layer_done, busy}, 2'b01);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    layer_start = 1'b0; compute_done = 1'b0; store_done = 1'b0;
    out_x = '0; out_y = '0; out_f = '0; tile_x = '0; tile_y = '0; tile_f = '0;
    tick;
    tick;
    reset = 1'b0;
    check_all_zero("por");
    tick;

    // 8x8x40 in 4x4x32 tiles, done pulses 2 cycles after each start.
    do_layer(8, 8, 40, 4, 4, 32, 1, 1, 1'b0, -1);
    tick;
    // Right-edge clipping in x and y.
    do_layer(5, 3, 16, 4, 4, 16, -1, -1, 1'b0, -1);
    // Zero-dimension layers.
    do_layer(5, 5, 0, 4, 4, 4, 0, 0, 1'b0, -1);
    do_layer(5, 5, 5, 0, 4, 4, 0, 0, 1'b0, -1);
    // Spurious handshakes and mid-layer layer_start.
    do_layer(6, 6, 6, 4, 4, 4, 2, 2, 1'b1, -1);
    // Reset in SWAIT of the 3rd tile, then a clean restart.
    do_layer(8, 8, 40, 4, 4, 32, 1, 1, 1'b0, 2);
    do_layer(8, 8, 40, 4, 4, 32, 0, 0, 1'b0, -1);
    // Latency: compute_done at cycle 5, store_done at cycle 9.
    do_layer(4, 4, 16, 4, 4, 16, 2, 2, 1'b0, -1);
    // Extents that reach the top of the DW range.
    do_layer(65535, 1, 1, 40000, 1, 1, 0, 0, 1'b0, -1);
    do_layer(1, 65535, 1, 1, 65535, 1, 0, 0, 1'b0, -1);
    tick;
    // Randomized layers.
    repeat (10) begin
      do_layer(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
               int'($urandom_range(1, 9)), int'($urandom_range(2, 6)),
               int'($urandom_range(2, 6)), int'($urandom_range(2, 6)),
               -1, -1, 1'($urandom_range(0, 1)), -1);
      repeat (int'($urandom_range(0, 2))) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_tile_sequencer.md
# conv_tile_sequencer

Layer-level scheduler that walks an output feature map in (ox, oy, of) tiles and drives one compute/store handshake per tile. For each tile it produces the 1-based tile origin and the edge-clipped tile extents consumed by the conv store controller (`cur_*_start`, `cur_po*`). It pulses `compute_start` and waits for `compute_done`, then pulses `conv_store_start` and waits for `store_done` (the store controller's tile-end pulse) before advancing. It sits between the layer-config/host logic and the conv core plus conv store path.

## Interface
- `DW`, 16, width of all dimension, start and extent buses.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `layer_start`  in  1  single-cycle request to run a layer; sampled only in IDLE.
- `out_x`, `out_y`, `out_f`  in  DW each  layer output width, height and channel count; latched on accepted `layer_start`.
- `tile_x`, `tile_y`, `tile_f`  in  DW each  nominal tile sizes; latched on accepted `layer_start`.
- `compute_done`  in  1  conv core finished the current tile; honoured only in CWAIT.
- `store_done`  in  1  store path finished the current tile; honoured only in SWAIT.
- `cur_ox_start`, `cur_oy_start`, `cur_of_start`  out  DW each  1-based tile origin.
- `cur_pox`, `cur_poy`, `cur_pof`  out  DW each  clipped tile extents.
- `compute_start`  out  1  one-cycle pulse, start compute of the current tile.
- `conv_store_start`  out  1  one-cycle pulse, start store of the current tile.
- `busy`  out  1  high in every state except IDLE.
- `layer_done`  out  1  one-cycle pulse at end of layer.
- `tile_count`  out  DW  tiles fully stored in the current layer.

## Operation
- States: IDLE, SIZE, CISSUE, CWAIT, SISSUE, SWAIT, ADVANCE, DONE. The state register is one-hot or encoded; all outputs are registered or decoded from the registered state only.
- IDLE: on `layer_start`, latch the six config values, set all starts to 1, clear `tile_count`.
  - If any latched value is 0, go to DONE (no tiles issued).
  - Otherwise go to SIZE.
- SIZE: register `cur_pox = min(tile_x, out_x - cur_ox_start + 1)`; same rule for y and f. Compute the subtraction at DW+1 bits. Go to CISSUE.
- CISSUE: `compute_start` = 1. Go to CWAIT.
- CWAIT: wait for `compute_done`, then go to SISSUE.
- SISSUE: `conv_store_start` = 1. Go to SWAIT.
- SWAIT: on `store_done`, increment `tile_count` (wraps modulo 2^DW). Then:
  - last tile → DONE;
  - otherwise → ADVANCE.
- Last tile: `cur_ox_start + cur_pox > out_x` and the same holds for y and f.
- ADVANCE: ox is the innermost loop, then oy, of outermost.
  - `cur_ox_start += cur_pox`.
  - If that exceeds `out_x`: reset ox to 1 and step oy by `cur_poy`.
  - If oy then exceeds `out_y`: reset oy to 1 and step of by `cur_pof`.
  - Go to SIZE.
- DONE: `layer_done` = 1. Go to IDLE.
- `cur_*` values hold stable from SIZE through SWAIT of each tile, and hold their last values in IDLE.
- Ignored events:
  - `layer_start` while `busy`.
  - `compute_done` outside CWAIT.
  - `store_done` outside SWAIT.
  - `compute_done` and `store_done` high in the same cycle: only the one matching the current state acts.
- Config inputs may change freely while `busy`; only the latched copies are used.

## Timing
- Reset, including mid-layer: next cycle is IDLE. All outputs are 0, including `cur_*`, `tile_count` and every pulse. No further pulses are emitted until a new `layer_start`.
- Cycle numbering counts cycles after the input is sampled high.
- `layer_start` high in cycle 0 → SIZE in cycle 1 → `compute_start` high in cycle 2. `busy` is high from cycle 1.
- `compute_done` in cycle k → `conv_store_start` in cycle k+1.
- `store_done` in cycle m, not last tile → new `cur_*` visible in cycle m+2 → `compute_start` in cycle m+3.
- `store_done` in cycle m, last tile → `layer_done` in cycle m+1 → IDLE with `busy` = 0 in cycle m+2.
- `compute_done` already high in the first CWAIT cycle (cycle 3) is accepted.
- Minimum per-tile period is 6 cycles.
- Zero-dimension layer: `layer_start` in cycle 0 → `layer_done` in cycle 1, with no start pulses.

## Test plan
- Config out=8×8×40, tile=4×4×32, `compute_done` and `store_done` each returned 2 cycles after their start pulse:
  - expect 8 tiles in order (ox,oy,of) = (1,1,1),(5,1,1),(1,5,1),(5,5,1),(1,1,33),(5,1,33),(1,5,33),(5,5,33);
  - `cur_pof` is 32 for the first four tiles and 8 for the last four;
  - `tile_count` ends at 8 and `layer_done` pulses once.
- Config out=5×3×16, tile=4×4×16 → tiles (1,1,1) with pox=4, poy=3, then (5,1,1) with pox=1, poy=3; 2 tiles total.
- Zero dimension: `out_f`=0 → `layer_done` the cycle after `layer_start`; `compute_start` and `conv_store_start` never assert.
- Spurious handshakes:
  - `store_done` pulsed during CWAIT → ignored;
  - `layer_start` pulsed mid-layer → ignored;
  - `compute_done` and `store_done` asserted together in SWAIT → only the store step advances.
- Reset asserted in SWAIT of the 3rd tile → all outputs 0 next cycle. A fresh `layer_start` then restarts from (1,1,1) with `tile_count`=0.
- Latency check with out=tile=4×4×16: `layer_start` in cycle 0 → `compute_start` in cycle 2. `compute_done` in cycle 5 → `conv_store_start` in cycle 6. `store_done` in cycle 9 → `layer_done` in cycle 10.
